// File: rtl/gcd_lcm_pkg.sv
// Shared definitions for the GCD/LCM coprocessor.
// Contents: FSM state enum, opcode enum, command-word field positions and
// default operand/result widths.
package gcd_lcm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    typedef enum logic {
        OP_GCD = 1'b0,
        OP_LCM = 1'b1
    } op_t;

    // Command word layout: A in [7:0], B in [15:8], opcode in [16].
    localparam int A_LSB  = 0;
    localparam int B_LSB  = 8;
    localparam int OP_BIT = 16;

    localparam int OPW_DEF  = 8;
    localparam int RESW_DEF = 16;

endpackage

// File: rtl/gcd_lcm_step.sv
// One iteration of the GCD (subtractive) or LCM (additive multiples) search.
// Purely combinational.
// Ports:
//   op              opcode of the running command
//   a, b            original operands
//   x, y            current working values (x/y for GCD, mx/my for LCM)
//   x_nxt, y_nxt    working values after this step
//   fin             command completes this cycle
//   fin_val         value to publish as the result when fin is high
module gcd_lcm_step
    import gcd_lcm_pkg::*;
#(
    parameter int OPW  = OPW_DEF,
    parameter int RESW = RESW_DEF
) (
    input  op_t             op,
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    input  logic [RESW-1:0] x,
    input  logic [RESW-1:0] y,
    output logic [RESW-1:0] x_nxt,
    output logic [RESW-1:0] y_nxt,
    output logic            fin,
    output logic [RESW-1:0] fin_val
);

    always_comb begin
        x_nxt   = x;
        y_nxt   = y;
        fin     = 1'b0;
        fin_val = '0;

        if (a == '0 || b == '0) begin
            // Zero operand: GCD is the other operand (0 for both zero),
            // LCM is defined as 0. No iteration needed.
            fin     = 1'b1;
            fin_val = (op == OP_GCD) ? RESW'(a | b) : '0;
        end else if (x == y) begin
            fin     = 1'b1;
            fin_val = x;
        end else if (op == OP_GCD) begin
            if (x > y) x_nxt = x - y;
            else       y_nxt = y - x;
        end else begin
            // Advance whichever multiple lags behind until they meet.
            if (x < y) x_nxt = x + RESW'(a);
            else       y_nxt = y + RESW'(b);
        end
    end

endmodule

// File: rtl/gcd_lcm_coproc.sv
// GCD/LCM coprocessor responding to the core's Start strobe. Captures the
// packed command word, iterates one step per clock, publishes a held result
// with a one-cycle done pulse.
// Optional feature macro: GCDLCM_ITER_COUNT_EN adds the iter_count port and
// a step counter.
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   start       command strobe (ignored while busy)
//   wd          command word: [7:0]=A, [15:8]=B, [16]=op (0 GCD, 1 LCM)
//   busy        command executing
//   done        one-cycle pulse when result updates
//   result      last completed result
//   rd_data     result zero-extended to 32 bits
//   iter_count  steps used by last command (GCDLCM_ITER_COUNT_EN only)
module gcd_lcm_coproc
    import gcd_lcm_pkg::*;
#(
    parameter int OPW  = OPW_DEF,
    parameter int RESW = RESW_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [31:0]     wd,
    output logic            busy,
    output logic            done,
    output logic [RESW-1:0] result,
    output logic [31:0]     rd_data
`ifdef GCDLCM_ITER_COUNT_EN
    ,
    output logic [15:0]     iter_count
`endif
);

    state_t          state_q, state_d;
    logic            accept;
    logic            finish;

    op_t             op_q;
    logic [OPW-1:0]  a_q, b_q;
    logic [RESW-1:0] x_q, y_q;

    logic [RESW-1:0] x_nxt, y_nxt, fin_val;
    logic            step_fin;

    // Upper command bits carry no information.
    logic            unused_wd_hi;
    assign unused_wd_hi = ^wd[31:OP_BIT+1];

    gcd_lcm_step #(
        .OPW  (OPW),
        .RESW (RESW)
    ) u_step (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .x       (x_q),
        .y       (y_q),
        .x_nxt   (x_nxt),
        .y_nxt   (y_nxt),
        .fin     (step_fin),
        .fin_val (fin_val)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (step_fin) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            done    <= finish;
            if (finish) result <= fin_val;
        end
    end

    // Working registers need no reset: they are always loaded on accept
    // before being consumed in CALC.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op_t'(wd[OP_BIT]);
            a_q  <= wd[A_LSB +: OPW];
            b_q  <= wd[B_LSB +: OPW];
            x_q  <= RESW'(wd[A_LSB +: OPW]);
            y_q  <= RESW'(wd[B_LSB +: OPW]);
        end else if (state_q == CALC) begin
            x_q <= x_nxt;
            y_q <= y_nxt;
        end
    end

    assign rd_data = {{(32-RESW){1'b0}}, result};

`ifdef GCDLCM_ITER_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            iter_count <= '0;
        end else begin
            if (accept)
                cnt_q <= '0;
            else if (state_q == CALC && !step_fin)
                cnt_q <= cnt_q + 16'd1;
            if (finish) iter_count <= cnt_q;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
module tb_gcd_lcm_coproc;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [31:0] rd_data;
`ifdef GCDLCM_ITER_COUNT_EN
    logic [15:0] iter_count;
`endif

    int checks = 0;
    int errors = 0;

    gcd_lcm_coproc dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .wd         (wd),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .rd_data    (rd_data)
`ifdef GCDLCM_ITER_COUNT_EN
        ,
        .iter_count (iter_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command at the negedge; returns 1 ns after edge 0.
    task automatic issue(input logic [31:0] w);
        @(negedge clk);
        start = 1'b1;
        wd    = w;
        @(posedge clk);
        #1;
        start = 1'b0;
        wd    = 32'h0;
    endtask

    // Count edges after edge 0 until done is seen (sampled 1 ns after edge).
    // edges = -1 on timeout.
    task automatic wait_done(input int limit, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            #1;
        end while (!done && edges < limit);
        if (!done) edges = -1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            wd    = $urandom;
            @(posedge clk);
            #1;
            checks++;
            if ({busy, done, result, rd_data} !== 50'h0) begin
                errors++;
                $display("FAIL reset_outputs: got busy=%0b done=%0b result=%0d rd_data=%0h required all 0",
                         busy, done, result, rd_data);
            end
`ifdef GCDLCM_ITER_COUNT_EN
            checks++;
            if (iter_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_iter: got %0d required 0", iter_count);
            end
`endif
        end
        @(negedge clk);
        start   = 1'b0;
        wd      = 32'h0;
        reset_n = 1'b1;
    endtask

    task automatic test_gcd;
        int e;
        issue(32'h0000_080C);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL gcd_busy: got %0b required 1", busy);
        end
        wait_done(20, e);
        checks++;
        if (e !== 3) begin
            errors++;
            $display("FAIL gcd_latency: got %0d required 3", e);
        end
        checks++;
        if (result !== 16'd4 || rd_data !== 32'h0000_0004) begin
            errors++;
            $display("FAIL gcd_result: got result=%0d rd_data=%0h required 4 / 4", result, rd_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL gcd_busy_at_done: got %0b required 0", busy);
        end
`ifdef GCDLCM_ITER_COUNT_EN
        checks++;
        if (iter_count !== 16'd2) begin
            errors++;
            $display("FAIL gcd_iter: got %0d required 2", iter_count);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || result !== 16'd4) begin
            errors++;
            $display("FAIL gcd_pulse_hold: got done=%0b result=%0d required 0 / 4", done, result);
        end
    endtask

    task automatic test_lcm;
        int e;
        issue(32'h0001_0604);
        wait_done(20, e);
        checks++;
        if (e !== 4 || result !== 16'd12) begin
            errors++;
            $display("FAIL lcm_4_6: got edges=%0d result=%0d required 4 / 12", e, result);
        end
`ifdef GCDLCM_ITER_COUNT_EN
        checks++;
        if (iter_count !== 16'd3) begin
            errors++;
            $display("FAIL lcm_4_6_iter: got %0d required 3", iter_count);
        end
`endif
        issue(32'h0001_FEFF);
        wait_done(700, e);
        checks++;
        if (e !== 508 || result !== 16'd64770 || rd_data !== 32'd64770) begin
            errors++;
            $display("FAIL lcm_255_254: got edges=%0d result=%0d rd_data=%0d required 508 / 64770 / 64770",
                     e, result, rd_data);
        end
`ifdef GCDLCM_ITER_COUNT_EN
        checks++;
        if (iter_count !== 16'd507) begin
            errors++;
            $display("FAIL lcm_255_254_iter: got %0d required 507", iter_count);
        end
`endif
    endtask

    task automatic test_zero_operands;
        int e;
        logic [31:0] cmd [3] = '{32'h0000_0000, 32'h0000_0900, 32'h0001_0700};
        logic [15:0] exp [3] = '{16'd0, 16'd9, 16'd0};
        for (int i = 0; i < 3; i++) begin
            issue(cmd[i]);
            wait_done(10, e);
            checks++;
            if (e !== 1 || result !== exp[i]) begin
                errors++;
                $display("FAIL zero_op_%0d: got edges=%0d result=%0d required 1 / %0d", i, e, result, exp[i]);
            end
`ifdef GCDLCM_ITER_COUNT_EN
            checks++;
            if (iter_count !== 16'd0) begin
                errors++;
                $display("FAIL zero_op_%0d_iter: got %0d required 0", i, iter_count);
            end
`endif
        end
    endtask

    task automatic test_ignored_start;
        int  k;
        int  extra;
        int  e;
        issue(32'h0000_01FF);
        k = 0;
        while (k < 400 && !done) begin
            @(negedge clk);
            start = (k + 1 == 10);
            wd    = start ? 32'h0001_0503 : 32'h0;
            @(posedge clk);
            k++;
            #1;
        end
        start = 1'b0;
        wd    = 32'h0;
        checks++;
        if (k !== 255 || result !== 16'd1) begin
            errors++;
            $display("FAIL ignored_start: got edges=%0d result=%0d required 255 / 1", k, result);
        end
`ifdef GCDLCM_ITER_COUNT_EN
        checks++;
        if (iter_count !== 16'd254) begin
            errors++;
            $display("FAIL ignored_start_iter: got %0d required 254", iter_count);
        end
`endif
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL no_second_done: got %0d busy/done cycles required 0", extra);
        end

        // Start presented in the done cycle must be accepted.
        issue(32'h0000_080C);
        wait_done(20, e);
        start = 1'b1;
        wd    = 32'h0001_0503;
        @(posedge clk);
        #1;
        start = 1'b0;
        wd    = 32'h0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle_accept: got busy=%0b required 1", busy);
        end
        wait_done(40, e);
        checks++;
        if (e !== 7 || result !== 16'd15) begin
            errors++;
            $display("FAIL done_cycle_lcm_3_5: got edges=%0d result=%0d required 7 / 15", e, result);
        end
    endtask

    task automatic test_mid_reset;
        int seen;
        int e;
        issue(32'h0000_01FF);
        for (int i = 1; i < 50; i++) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'd0 || rd_data !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_clear: got busy=%0b done=%0b result=%0d rd_data=%0h required all 0",
                     busy, done, result, rd_data);
        end
`ifdef GCDLCM_ITER_COUNT_EN
        checks++;
        if (iter_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_iter: got %0d required 0", iter_count);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_done: got %0d busy/done cycles required 0", seen);
        end
        issue(32'h0001_0604);
        wait_done(20, e);
        checks++;
        if (e !== 4 || result !== 16'd12) begin
            errors++;
            $display("FAIL post_reset_cmd: got edges=%0d result=%0d required 4 / 12", e, result);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        wd      = 32'h0;
        test_reset();
        test_gcd();
        test_lcm();
        test_zero_operands();
        test_ignored_start();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_lcm_coproc.md
# gcd_lcm_coproc

Responder-side GCD/LCM coprocessor for the single-cycle RISC-V core. It accepts the packed operand word the core's datapath drives when `Start` is high: operand A in bits 7:0, operand B in bits 15:8, opcode in bit 16, zero above. It computes the result iteratively, one step per clock. It returns a 16-bit result, zero-extended to 32 bits, on the core's read-data path, with busy/done status.

## Interface
Parameters:
- `OPW`, 8: operand width (bits per operand in the command word).
- `RESW`, 16: result width (2*OPW).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe from core (Start).
- `wd`  in  32  command word: [7:0]=A, [15:8]=B, [16]=op (0=GCD, 1=LCM), [31:17] ignored.
- `busy`  out  1  high while a command is executing.
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `result`  out  RESW  last completed result, held until next completion.
- `rd_data`  out  32  `result` zero-extended, for the core ReadData mux.
- `iter_count`  out  16  steps used by last command (only with `GCDLCM_ITER_COUNT_EN`).

## Operation
- States: IDLE, CALC.
- In IDLE, `start`=1 captures A, B, op into internal registers and moves to CALC.
  - GCD loads x=A, y=B.
  - LCM loads mx=A, my=B (RESW-bit accumulators).
- CALC, GCD step:
  - If A==0 or B==0: result=A|B, finish (GCD(0,0)=0).
  - Else if x==y: result=x, finish.
  - Else subtract the smaller from the larger.
- CALC, LCM step:
  - If A==0 or B==0: result=0, finish.
  - Else if mx==my: result=mx, finish.
  - Else if mx<my: mx+=A; otherwise my+=B.
- Finish: load `result`, pulse `done` for exactly one cycle, return to IDLE.
- `start` while busy is ignored; the in-flight command is unaffected and no queueing occurs.
- `start` on the same cycle `done` is high (state is IDLE) is accepted normally.
- `wd[31:17]` is don't-care.
- Arithmetic is unsigned. LCM max is 255*254=64770, so RESW accumulators cannot overflow. No saturation logic.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, `rd_data`=0, `iter_count`=0.
- Asserting `reset_n` mid-command aborts it immediately. No `done` is produced, and `result` is cleared.
- Let edge 0 be the edge that samples `start`. `busy` is high from after edge 0 until the finishing edge.
- For a command needing N update steps, `done` is high and `result` is valid after edge N+1, and `busy` is low in that same cycle.
- Zero-operand commands: N=0, so `done` appears after edge 1.
- Worst cases for OPW=8:
  - GCD(255,1): N=254.
  - LCM(255,254): N=507.
- `rd_data` is combinationally equal to {16'b0, `result`}.

## Configuration
- `GCDLCM_ITER_COUNT_EN` defined:
  - A 16-bit step counter clears on command acceptance and increments on each non-finishing CALC cycle.
  - Its value is copied to `iter_count` at finish.
- Not defined: the `iter_count` port and counter are absent. All other behaviour is identical.

## Structure
- Package `gcd_lcm_pkg` holds:
  - the state enum (IDLE, CALC) and the op enum (OP_GCD=0, OP_LCM=1);
  - field constants for `wd`: A_LSB=0, B_LSB=8, OP_BIT=16;
  - OPW and RESW defaults.
- One sub-module, `gcd_lcm_step`: combinational next-value and finish logic for one iteration. Inputs are op, A, B, x/mx, y/my. Outputs are next x/mx, next y/my, finish, and finish value.
- The top level holds the FSM and registers.

## Test plan
- Reset: hold `reset_n`=0 with random `start`/`wd`. All outputs stay 0.
- GCD: `wd`=0x0000_080C (A=12, B=8, op=0) with `start` for 1 cycle. `done` pulses after edge 3, `result`=4, `rd_data`=0x0000_0004, `iter_count`=2.
- LCM: `wd`=0x0001_0604 (A=4, B=6). `done` after edge 4, `result`=12, `iter_count`=3. Also LCM(255,254): `result`=64770, `done` after edge 508.
- Zero operands, each with `done` after edge 1:
  - GCD(0,9) → 9.
  - GCD(0,0) → 0.
  - LCM(0,7) → 0.
- Ignored start: issue GCD(255,1), then pulse `start` with LCM(3,5) at cycle 10. Result is 1 after edge 255 and no second `done` follows. Then a `start` on the `done` cycle with LCM(3,5) is accepted and gives 15.
- Mid-command reset: drop `reset_n` at cycle 50 of GCD(255,1). Outputs go to 0 at once, no `done` appears, and the next command completes correctly.
